// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control unit.
// Moore FSM with a registered opcode/funct decode captured in ID.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        MIO_ready,
    input  logic        zero,
    input  logic        overflow,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LW_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXE    = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic       ovf_q, ovf_d;
    logic [2:0] alu_r, alu_i;

    // zero is consumed by the datapath's PC-load gate, not here.
    logic unused_in;
    assign unused_in = ^{zero, Inst[25:6]};

    // ALU function for R-type execute, from the latched funct field.
    always_comb begin
        alu_r = ALU_ADD;
        case (fn_q)
            FN_ADD:  alu_r = ALU_ADD;
            FN_SUB:  alu_r = ALU_SUB;
            FN_AND:  alu_r = ALU_AND;
            FN_OR:   alu_r = ALU_OR;
            FN_XOR:  alu_r = ALU_XOR;
            FN_NOR:  alu_r = ALU_NOR;
            FN_SLT:  alu_r = ALU_SLT;
            FN_SRL:  alu_r = ALU_SRL;
            default: alu_r = ALU_ADD;
        endcase
    end

    // ALU function for I-type execute, from the latched opcode.
    always_comb begin
        alu_i = ALU_ADD;
        case (op_q)
            OP_SLTI: alu_i = ALU_SLT;
            OP_ANDI: alu_i = ALU_AND;
            OP_ORI:  alu_i = ALU_OR;
            default: alu_i = ALU_ADD;
        endcase
    end

    // Next-state, decode latch and overflow-flag logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IF: begin
                ovf_d = 1'b0;
                if (MIO_ready) state_d = S_ID;
            end
            S_ID: begin
                op_d = Inst[31:26];
                fn_d = Inst[5:0];
                case (Inst[31:26])
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:
                        state_d = (Inst[5:0] == FN_JR) ? S_JR : S_R_EXE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:
                        state_d = S_I_EXE;
                    default:        state_d = S_IF;
                endcase
            end
            S_MEM_ADDR:
                state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:
                if (MIO_ready) state_d = S_LW_WB;
            S_MEM_WR:
                if (MIO_ready) state_d = S_IF;
            S_R_EXE: begin
                ovf_d   = overflow & ((fn_q == FN_ADD) | (fn_q == FN_SUB));
                state_d = S_R_WB;
            end
            S_I_EXE: begin
                ovf_d   = overflow & (op_q == OP_ADDI);
                state_d = S_I_WB;
            end
            default: state_d = S_IF;
        endcase
    end

    // State and decode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            op_q    <= '0;
            fn_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            ovf_q   <= ovf_d;
        end
    end

    // Moore outputs from state; IF write strobes wait on memory.
    always_comb begin
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = 3'b000;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        CPU_MIO       = 1'b0;
        state         = reset ? 4'd0 : state_q;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    MemRead       = 1'b1;
                    CPU_MIO       = 1'b1;
                    IRWrite       = MIO_ready;
                    PCWrite       = MIO_ready;
                    ALUSrcB       = 2'b01;
                    ALU_operation = ALU_ADD;
                end
                S_ID: begin
                    ALUSrcB       = 2'b11;
                    ALU_operation = ALU_ADD;
                end
                S_MEM_ADDR: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = 2'b10;
                    ALU_operation = ALU_ADD;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                end
                S_LW_WB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    CPU_MIO  = 1'b1;
                end
                S_R_EXE: begin
                    ALUSrcA       = 1'b1;
                    ALU_operation = alu_r;
                end
                S_R_WB: begin
                    RegDst   = 2'b01;
                    RegWrite = ~ovf_q;
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ALU_operation = ALU_SUB;
                    PCSource      = 2'b01;
                    PCWriteCond   = 1'b1;
                    Branch        = (op_q == OP_BEQ);
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_JAL: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
                S_JR: begin
                    PCSource = 2'b11;
                    PCWrite  = 1'b1;
                end
                S_I_EXE: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = 2'b10;
                    ALU_operation = alu_i;
                end
                S_I_WB: begin
                    RegWrite = ~ovf_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl.
// Each task walks a cycle-by-cycle table of expected state and controls.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Inst = '0;
    logic        MIO_ready = 1'b1;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite;
    logic        PCWriteCond, Branch;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [3:0]  state;
    logic [20:0] ctl;

    int n_chk = 0;
    int n_fail = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .Inst(Inst),
        .MIO_ready(MIO_ready), .zero(zero), .overflow(overflow),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .Branch(Branch),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation),
        .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .state(state)
    );

    always #5 clk = ~clk;

    // {IorD,IRWrite,RegWrite,ALUSrcA,PCWrite,PCWriteCond,Branch,
    //  RegDst,MemtoReg,ALUSrcB,PCSource,ALU,MemRead,MemWrite,CPU_MIO}
    assign ctl = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
                  PCWriteCond, Branch, RegDst, MemtoReg, ALUSrcB,
                  PCSource, ALU_operation, MemRead, MemWrite, CPU_MIO};

    localparam logic [20:0] E_IF  = {7'b0100100, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 3'b101};
    localparam logic [20:0] E_IFW = {7'b0000000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b010, 3'b101};
    localparam logic [20:0] E_ID  = {7'b0000000, 2'b00, 2'b00, 2'b11, 2'b00, 3'b010, 3'b000};
    localparam logic [20:0] E_MA  = {7'b0001000, 2'b00, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000};
    localparam logic [20:0] E_MRD = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b101};
    localparam logic [20:0] E_LWB = {7'b0010000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_MWR = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011};
    localparam logic [20:0] E_RWB = {7'b0010000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_RWN = {7'b0000000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_BEQ = {7'b0001011, 2'b00, 2'b00, 2'b00, 2'b01, 3'b110, 3'b000};
    localparam logic [20:0] E_BNE = {7'b0001010, 2'b00, 2'b00, 2'b00, 2'b01, 3'b110, 3'b000};
    localparam logic [20:0] E_JMP = {7'b0000100, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [20:0] E_JAL = {7'b0010100, 2'b10, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
    localparam logic [20:0] E_JR  = {7'b0000100, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_IWB = {7'b0010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_ZERO = '0;

    function automatic logic [20:0] e_rex(input logic [2:0] alu);
        return {7'b0001000, 2'b00, 2'b00, 2'b00, 2'b00, alu, 3'b000};
    endfunction

    function automatic logic [20:0] e_iex(input logic [2:0] alu);
        return {7'b0001000, 2'b00, 2'b00, 2'b10, 2'b00, alu, 3'b000};
    endfunction

    logic [31:0] qi[$];
    logic        qr[$];
    logic        qo[$];
    logic [3:0]  qs[$];
    logic [20:0] qc[$];

    task automatic clr();
        qi.delete(); qr.delete(); qo.delete(); qs.delete(); qc.delete();
    endtask

    task automatic push(input logic [31:0] i, input logic r, input logic o,
                        input logic [3:0] s, input logic [20:0] c);
        qi.push_back(i); qr.push_back(r); qo.push_back(o);
        qs.push_back(s); qc.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        MIO_ready = 1'b1;
        overflow = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Inst = 32'h8C220000;
        MIO_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            n_chk++;
            if (state !== 4'd0 || ctl !== E_ZERO) begin
                n_fail++;
                $display("FAIL reset_hold %0d: got state=%0d ctl=%h, want state=0 ctl=%h",
                         k, state, ctl, E_ZERO);
            end
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (state !== 4'd0 || ctl !== E_IF) begin
            n_fail++;
            $display("FAIL reset_release: got state=%0d ctl=%h, want state=0 ctl=%h",
                     state, ctl, E_IF);
        end
        tick();
        n_chk++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_first_edge: got state=%0d, want 1", state);
        end
    endtask

    task automatic test_rtype_add();
        do_reset();
        clr();
        push(32'h00000820, 1, 0, 4'd0, E_IF);
        push(32'h00000820, 1, 0, 4'd1, E_ID);
        push(32'h00000820, 1, 0, 4'd6, e_rex(3'b010));
        push(32'h00000820, 1, 0, 4'd7, E_RWB);
        push(32'h00000820, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL rtype_add step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fns[8];
        logic [2:0]  alus[8];
        logic [31:0] ins;
        fns  = '{6'b100010, 6'b100100, 6'b100101, 6'b100110,
                 6'b100111, 6'b101010, 6'b000010, 6'b111111};
        alus = '{3'b110, 3'b000, 3'b001, 3'b011,
                 3'b100, 3'b111, 3'b101, 3'b010};
        do_reset();
        clr();
        for (int j = 0; j < 8; j++) begin
            ins = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fns[j]};
            push(ins, 1, 0, 4'd0, E_IF);
            push(ins, 1, 0, 4'd1, E_ID);
            push(ins, 1, 0, 4'd6, e_rex(alus[j]));
            push(ins, 1, 0, 4'd7, E_RWB);
        end
        push(32'h0, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_itype();
        logic [5:0]  ops[4];
        logic [2:0]  alus[4];
        logic [31:0] ins;
        ops  = '{6'b001000, 6'b001010, 6'b001100, 6'b001101};
        alus = '{3'b010, 3'b111, 3'b000, 3'b001};
        do_reset();
        clr();
        for (int j = 0; j < 4; j++) begin
            ins = {ops[j], 5'd1, 5'd2, 16'h0005};
            push(ins, 1, 0, 4'd0, E_IF);
            push(ins, 1, 0, 4'd1, E_ID);
            push(ins, 1, 0, 4'd10, e_iex(alus[j]));
            push(ins, 1, 0, 4'd11, E_IWB);
        end
        push(32'h0, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL itype step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        do_reset();
        clr();
        push(32'h8C220000, 1, 0, 4'd0, E_IF);
        push(32'h8C220000, 1, 0, 4'd1, E_ID);
        push(32'h8C220000, 1, 0, 4'd2, E_MA);
        push(32'h8C220000, 0, 0, 4'd3, E_MRD);
        push(32'h8C220000, 0, 0, 4'd3, E_MRD);
        push(32'h8C220000, 0, 0, 4'd3, E_MRD);
        push(32'h8C220000, 1, 0, 4'd3, E_MRD);
        push(32'h8C220000, 1, 0, 4'd4, E_LWB);
        push(32'h8C220000, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL lw_wait step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_sw();
        do_reset();
        clr();
        push(32'hAC220000, 1, 0, 4'd0, E_IF);
        push(32'hAC220000, 1, 0, 4'd1, E_ID);
        push(32'hAC220000, 1, 0, 4'd2, E_MA);
        push(32'hAC220000, 1, 0, 4'd5, E_MWR);
        push(32'hAC220000, 1, 0, 4'd0, E_IF);
        push(32'hAC220000, 1, 0, 4'd1, E_ID);
        push(32'hAC220000, 1, 0, 4'd2, E_MA);
        push(32'hAC220000, 0, 0, 4'd5, E_MWR);
        push(32'hAC220000, 1, 0, 4'd5, E_MWR);
        push(32'hAC220000, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL sw step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        do_reset();
        clr();
        push(32'h10410002, 1, 0, 4'd0, E_IF);
        push(32'h10410002, 1, 0, 4'd1, E_ID);
        push(32'h10410002, 1, 0, 4'd8, E_BEQ);
        push(32'h14410002, 1, 0, 4'd0, E_IF);
        push(32'h14410002, 1, 0, 4'd1, E_ID);
        push(32'h14410002, 1, 0, 4'd8, E_BNE);
        push(32'h14410002, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL branch step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_jumps();
        do_reset();
        clr();
        push(32'h0C000008, 1, 0, 4'd0, E_IF);
        push(32'h0C000008, 1, 0, 4'd1, E_ID);
        push(32'h0C000008, 1, 0, 4'd12, E_JAL);
        push(32'h08000008, 1, 0, 4'd0, E_IF);
        push(32'h08000008, 1, 0, 4'd1, E_ID);
        push(32'h08000008, 1, 0, 4'd9, E_JMP);
        push(32'h03E00008, 1, 0, 4'd0, E_IF);
        push(32'h03E00008, 1, 0, 4'd1, E_ID);
        push(32'h03E00008, 1, 0, 4'd13, E_JR);
        push(32'h03E00008, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL jumps step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        clr();
        push(32'h00220820, 1, 0, 4'd0, E_IF);
        push(32'h00220820, 1, 0, 4'd1, E_ID);
        push(32'h00220820, 1, 1, 4'd6, e_rex(3'b010));
        push(32'h00220820, 1, 0, 4'd7, E_RWN);
        push(32'h00221822, 1, 0, 4'd0, E_IF);
        push(32'h00221822, 1, 0, 4'd1, E_ID);
        push(32'h00221822, 1, 0, 4'd6, e_rex(3'b110));
        push(32'h00221822, 1, 0, 4'd7, E_RWB);
        push(32'h20220005, 1, 0, 4'd0, E_IF);
        push(32'h20220005, 1, 0, 4'd1, E_ID);
        push(32'h20220005, 1, 1, 4'd10, e_iex(3'b010));
        push(32'h20220005, 1, 0, 4'd11, E_ZERO);
        push(32'h0022182A, 1, 0, 4'd0, E_IF);
        push(32'h0022182A, 1, 0, 4'd1, E_ID);
        push(32'h0022182A, 1, 1, 4'd6, e_rex(3'b111));
        push(32'h0022182A, 1, 0, 4'd7, E_RWB);
        push(32'h0022182A, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL overflow step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
        overflow = 1'b0;
    endtask

    task automatic test_if_wait();
        do_reset();
        clr();
        push(32'h08000008, 0, 0, 4'd0, E_IFW);
        push(32'h08000008, 0, 0, 4'd0, E_IFW);
        push(32'h08000008, 1, 0, 4'd0, E_IF);
        push(32'h08000008, 1, 0, 4'd1, E_ID);
        push(32'h08000008, 1, 0, 4'd9, E_JMP);
        push(32'h08000008, 1, 0, 4'd0, E_IF);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL if_wait step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    task automatic test_reset_in_memwr();
        do_reset();
        clr();
        push(32'hAC220000, 1, 0, 4'd0, E_IF);
        push(32'hAC220000, 1, 0, 4'd1, E_ID);
        push(32'hAC220000, 1, 0, 4'd2, E_MA);
        push(32'hAC220000, 0, 0, 4'd5, E_MWR);
        push(32'hAC220000, 0, 0, 4'd5, E_MWR);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL memwr_pre step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
        MIO_ready = 1'b0;
        reset = 1'b1;
        tick();
        #1;
        n_chk++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || ctl !== E_ZERO) begin
            n_fail++;
            $display("FAIL memwr_reset: got state=%0d MemWrite=%b ctl=%h, want state=0 MemWrite=0 ctl=%h",
                     state, MemWrite, ctl, E_ZERO);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (state !== 4'd0 || ctl !== E_IFW) begin
            n_fail++;
            $display("FAIL memwr_release: got state=%0d ctl=%h, want state=0 ctl=%h",
                     state, ctl, E_IFW);
        end
        MIO_ready = 1'b1;
        tick();
        n_chk++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL memwr_restart: got state=%0d, want 1", state);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        clr();
        push(32'hFC000000, 1, 0, 4'd0, E_IF);
        push(32'hFC000000, 1, 0, 4'd1, E_ID);
        push(32'h3C010005, 1, 0, 4'd0, E_IF);
        push(32'h3C010005, 1, 0, 4'd1, E_ID);
        push(32'h3C010005, 1, 0, 4'd0, E_IF);
        push(32'h3C010005, 1, 0, 4'd1, E_ID);
        for (int k = 0; k < qs.size(); k++) begin
            Inst = qi[k]; MIO_ready = qr[k]; overflow = qo[k];
            #1;
            n_chk++;
            if (state !== qs[k] || ctl !== qc[k]) begin
                n_fail++;
                $display("FAIL illegal step %0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                         k, state, ctl, qs[k], qc[k]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_back_to_back();
        test_itype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jumps();
        test_overflow();
        test_if_wait();
        test_reset_in_memwr();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
